// File: rtl/ncl_reg_stage.sv
// Clocked NCL register stage: per-bit TH22 hysteresis on each rail against the downstream
// request, OR-based bit completion, and a registered TH22 reduction into stage completion.
module ncl_reg_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             init_n,
    input  logic [WIDTH-1:0] d_rail0,
    input  logic [WIDTH-1:0] d_rail1,
    input  logic             ack_in,
    output logic [WIDTH-1:0] q_rail0,
    output logic [WIDTH-1:0] q_rail1,
    output logic [WIDTH-1:0] bit_comp,
    output logic             comp,
    output logic             ko,
    output logic             err
);

    // Handshake: ack_in=1 asks for a DATA wavefront and ack_in=0 asks for NULL. A rail
    // captures only when it agrees with ack_in and holds otherwise. ko goes low once every
    // bit holds DATA and high again once every bit has returned to NULL.
    logic [WIDTH-1:0] ack_vec;
    logic [WIDTH-1:0] q_rail0_next;
    logic [WIDTH-1:0] q_rail1_next;
    logic             all_data;
    logic             all_null;
    logic             comp_next;
    logic             illegal;

    assign ack_vec = {WIDTH{ack_in}};

    // TH22: set when both inputs are 1, clear when both are 0, otherwise keep the old value.
    always_comb begin
        q_rail0_next = (d_rail0 & ack_vec) | (q_rail0 & (d_rail0 | ack_vec));
        q_rail1_next = (d_rail1 & ack_vec) | (q_rail1 & (d_rail1 | ack_vec));
    end

    assign bit_comp = q_rail0 | q_rail1;

    // A mixed wavefront is neither all-data nor all-null, so comp holds its value.
    always_comb begin
        all_data  = &bit_comp;
        all_null  = ~|bit_comp;
        comp_next = all_data | (comp & ~all_null);
    end

    assign illegal = |(d_rail0 & d_rail1);

    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            q_rail0 <= '0;
            q_rail1 <= '0;
            comp    <= 1'b0;
            err     <= 1'b0;
        end else begin
            q_rail0 <= q_rail0_next;
            q_rail1 <= q_rail1_next;
            comp    <= comp_next;
            err     <= err | illegal;
        end
    end

    assign ko = ~comp;

endmodule

// File: tb/tb_ncl_reg_stage.sv
// Directed bench for ncl_reg_stage: reset, DATA/NULL wavefronts, hold, partial
// wavefronts, reset mid-wavefront and the sticky illegal-code flag.
module tb_ncl_reg_stage;

    localparam int WIDTH = 32;

    logic             clk;
    logic             init_n;
    logic [WIDTH-1:0] d_rail0;
    logic [WIDTH-1:0] d_rail1;
    logic             ack_in;
    logic [WIDTH-1:0] q_rail0;
    logic [WIDTH-1:0] q_rail1;
    logic [WIDTH-1:0] bit_comp;
    logic             comp;
    logic             ko;
    logic             err;

    int n_compared;
    int n_mismatched;

    ncl_reg_stage #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .init_n   (init_n),
        .d_rail0  (d_rail0),
        .d_rail1  (d_rail1),
        .ack_in   (ack_in),
        .q_rail0  (q_rail0),
        .q_rail1  (q_rail1),
        .bit_comp (bit_comp),
        .comp     (comp),
        .ko       (ko),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [WIDTH-1:0] got,
                            input logic [WIDTH-1:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and sample 1 ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [WIDTH-1:0] r1, input logic [WIDTH-1:0] r0,
                         input logic a);
        d_rail1 = r1;
        d_rail0 = r0;
        ack_in  = a;
    endtask

    task automatic check_q(input string tag, input logic [WIDTH-1:0] e1,
                           input logic [WIDTH-1:0] e0);
        check_eq({tag, ".q_rail1"}, q_rail1, e1);
        check_eq({tag, ".q_rail0"}, q_rail0, e0);
        check_eq({tag, ".bit_comp"}, bit_comp, e1 | e0);
    endtask

    task automatic check_comp(input string tag, input logic e);
        check_eq({tag, ".comp"}, {31'd0, comp}, {31'd0, e});
        check_eq({tag, ".ko"}, {31'd0, ko}, {31'd0, ~e});
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        init_n = 1'b1;
        drive(32'h0, 32'h0, 1'b0);

        // Reset with live inputs, no clock edge yet.
        #1;
        init_n = 1'b0;
        drive(32'hFFFF_FFFF, 32'h0, 1'b1);
        #2;
        check_q("rst_async", 32'h0, 32'h0);
        check_comp("rst_async", 1'b0);
        check_eq("rst_async.err", {31'd0, err}, 32'd0);

        // Inputs are ignored while reset is held across edges.
        step();
        step();
        check_q("rst_held", 32'h0, 32'h0);
        check_comp("rst_held", 1'b0);

        drive(32'h0, 32'h0, 1'b0);
        init_n = 1'b1;
        step();
        check_q("rst_rel", 32'h0, 32'h0);
        check_comp("rst_rel", 1'b0);

        // DATA capture of value 1.
        drive(32'h0000_0001, 32'hFFFF_FFFE, 1'b1);
        step();
        check_q("data_e1", 32'h0000_0001, 32'hFFFF_FFFE);
        check_comp("data_e1", 1'b0);
        step();
        check_comp("data_e2", 1'b1);

        // Hold: ack_in low but rail1[0] still high keeps q_rail1[0].
        drive(32'h0000_0001, 32'h0, 1'b0);
        step();
        check_q("hold_e1", 32'h0000_0001, 32'h0);
        check_comp("hold_e1", 1'b1);
        step();
        check_comp("hold_e2", 1'b1);

        // NULL return.
        drive(32'h0, 32'h0, 1'b0);
        step();
        check_q("null_e1", 32'h0, 32'h0);
        check_comp("null_e1", 1'b1);
        step();
        check_comp("null_e2", 1'b0);

        // Partial DATA on bits 0..15 never completes.
        drive(32'h0000_A5A5, 32'h0000_5A5A, 1'b1);
        step();
        check_q("part_lo", 32'h0000_A5A5, 32'h0000_5A5A);
        for (int i = 0; i < 4; i++) begin
            step();
            check_comp("part_wait", 1'b0);
        end
        drive(32'h3C3C_A5A5, 32'hC3C3_5A5A, 1'b1);
        step();
        check_q("part_hi", 32'h3C3C_A5A5, 32'hC3C3_5A5A);
        check_comp("part_hi_e1", 1'b0);
        step();
        check_comp("part_hi_e2", 1'b1);

        // ack_in falls with inputs still DATA: every rail holds.
        drive(32'h3C3C_A5A5, 32'hC3C3_5A5A, 1'b0);
        step();
        check_q("ack_drop", 32'h3C3C_A5A5, 32'hC3C3_5A5A);
        // Upper half returns to NULL: mixed wavefront, comp holds.
        drive(32'h0000_A5A5, 32'h0000_5A5A, 1'b0);
        step();
        check_q("mixed_null", 32'h0000_A5A5, 32'h0000_5A5A);
        step();
        check_comp("mixed_null", 1'b1);
        drive(32'h0, 32'h0, 1'b0);
        step();
        step();
        check_comp("all_null", 1'b0);

        // Reset mid-wavefront discards the partial data.
        drive(32'h0000_00F0, 32'h0000_000F, 1'b1);
        step();
        check_q("mid_pre", 32'h0000_00F0, 32'h0000_000F);
        init_n = 1'b0;
        #1;
        check_q("mid_rst", 32'h0, 32'h0);
        drive(32'h0, 32'h0, 1'b0);
        #1;
        init_n = 1'b1;
        step();
        step();
        check_q("mid_resume", 32'h0, 32'h0);
        check_comp("mid_resume", 1'b0);

        // Illegal code on bit 5: err is sticky and rails are not masked.
        drive(32'h0000_0020, 32'hFFFF_FFFF, 1'b1);
        #1;
        check_eq("ill_pre.err", {31'd0, err}, 32'd0);
        step();
        check_eq("ill_e1.err", {31'd0, err}, 32'd1);
        check_q("ill_e1", 32'h0000_0020, 32'hFFFF_FFFF);
        drive(32'h0, 32'h0, 1'b0);
        step();
        step();
        check_eq("ill_sticky.err", {31'd0, err}, 32'd1);
        init_n = 1'b0;
        #1;
        check_eq("ill_rst.err", {31'd0, err}, 32'd0);
        init_n = 1'b1;
        step();
        check_eq("ill_after.err", {31'd0, err}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
